// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-byte holding register
//
// Serialises bytes LSB first as start(0), 8 data bits, stop(1), each bit
// lasting N = clock_frequency / baud_rate clocks (minimum 1). A holding
// register lets the client queue the next byte so frames run back to back.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   baud_rate   bits/s, sampled when a frame starts
//   data_in     byte offered by the client
//   data_valid  client offers data_in
//   data_ready  holding register empty (byte taken when valid & ready)
//   tx_out      serial line, idle high
//   busy        frame in progress (start, data or stop bit)
//   finished    one-cycle pulse on the last cycle of each stop bit

module uart_tx #(
  parameter int unsigned clock_frequency = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] baud_rate,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx_out,
  output logic        busy,
  output logic        finished
);

  localparam logic [31:0] CLK_FREQ = 32'(clock_frequency);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] n_q, n_d;
  logic [31:0] count_q, count_d;
  logic [3:0]  index_q, index_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        finished_q, finished_d;
  logic        ready_q, ready_d;

  logic [31:0] n_calc;
  logic        accept;
  logic        bit_end;

  // Bit period for the next frame; zero or over-fast baud rates fall back
  // to one clock per bit so the divider can never stall the transmitter.
  always_comb begin
    n_calc = 32'd1;
    if (baud_rate != 32'd0) begin
      n_calc = CLK_FREQ / baud_rate;
      if (n_calc == 32'd0) begin
        n_calc = 32'd1;
      end
    end
  end

  assign accept  = data_valid && ready_q;
  assign bit_end = (count_q == n_q - 32'd1);

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    n_d         = n_q;
    count_d     = count_q;
    index_d     = index_q;

    // ready_q mirrors !hold_full_q, so an accept can never collide with
    // the drain below (which needs hold_full_q set).
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = data_in;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_data_q;
          n_d         = n_calc;
          count_d     = 32'd0;
          hold_full_d = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          count_d = 32'd0;
          index_d = 4'd0;
          state_d = S_DATA;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          count_d = 32'd0;
          if (index_q == 4'd7) begin
            state_d = S_STOP;
          end else begin
            index_d = index_q + 4'd1;
          end
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          count_d = 32'd0;
          if (hold_full_q) begin
            // Chain straight into the next start bit with a fresh period.
            shift_d     = hold_data_q;
            n_d         = n_calc;
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          count_d = count_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so the registered pins line
  // up with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[index_d[2:0]];
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d != S_IDLE);
    finished_d = (state_d == S_STOP) && (count_d == n_d - 32'd1);
    ready_d    = !hold_full_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'd0;
      shift_q     <= 8'd0;
      n_q         <= 32'd1;
      count_q     <= 32'd0;
      index_q     <= 4'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      n_q         <= n_d;
      count_q     <= count_d;
      index_q     <= index_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      ready_q     <= ready_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign data_ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
module tb_uart_tx;

  localparam int unsigned CLK_HZ = 100000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] baud_rate = 32'd10000000;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        tx_out;
  logic        busy;
  logic        finished;

  uart_tx #(.clock_frequency(CLK_HZ)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_rate  (baud_rate),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active = 1'b0;
  bit   just_ended = 1'b0;
  bit   skip = 1'b0;
  int   bitn = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame monitor: samples on the falling edge and checks every cycle of
  // each frame against the expected byte and bit period.
  initial begin
    logic eb;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active     = 1'b0;
        just_ended = 1'b0;
        skip       = 1'b0;
        sb.delete();
      end else if (skip) begin
        if (!busy && tx_out) skip = 1'b0;
      end else begin
        if (!active) begin
          if (tx_out == 1'b0) begin
            if (sb.size() == 0) begin
              check_eq("unexpected_start", 32'd1, 32'd0);
              skip = 1'b1;
            end else begin
              cur    = sb.pop_front();
              active = 1'b1;
              bitn   = 0;
              cyc    = 0;
              if (cur.b2b) check_eq("b2b_gap", 32'(just_ended), 32'd1);
            end
          end else begin
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_finished", 32'(finished), 32'd0);
          end
          just_ended = 1'b0;
        end
        if (active) begin
          if (bitn == 0)      eb = 1'b0;
          else if (bitn == 9) eb = 1'b1;
          else                eb = cur.data[bitn-1];
          check_eq("tx_bit", 32'(tx_out), 32'(eb));
          check_eq("busy", 32'(busy), 32'd1);
          check_eq("finished", 32'(finished), 32'((bitn == 9) && (cyc == cur.n - 1)));
          cyc++;
          if (cyc == cur.n) begin
            cyc = 0;
            bitn++;
            if (bitn == 10) begin
              active     = 1'b0;
              just_ended = 1'b1;
            end
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  // with data_valid still high.
  task automatic send(input logic [7:0] b, input int n, input bit b2b);
    int t;
    exp_t e;
    t = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!data_ready) begin
      check_eq("send_timeout", 32'd0, 32'd1);
    end else begin
      e.data = b;
      e.n    = n;
      e.b2b  = b2b;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || active || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check_eq("idle_timeout", 32'(t < 5000), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx_out), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_finished", 32'(finished), 32'd0);
    check_eq("rst_ready", 32'(data_ready), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte from idle, N=10, first-bit latency.
    baud_rate = 32'd10000000;
    send(8'hA5, 10, 1'b0);
    data_valid = 1'b0;
    check_eq("lat_pre", 32'(tx_out), 32'd1);
    @(negedge clk);
    check_eq("lat_start", 32'(tx_out), 32'd0);
    wait_idle();

    // Back-to-back with data_valid held high.
    send(8'h00, 10, 1'b0);
    check_eq("ready_low_held", 32'(data_ready), 32'd0);
    send(8'hFF, 10, 1'b1);
    check_eq("ready_low_queued", 32'(data_ready), 32'd0);
    data_valid = 1'b0;
    wait_idle();

    // Baud change mid-frame only affects the queued byte.
    send(8'h3C, 10, 1'b0);
    send(8'hC3, 20, 1'b1);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    baud_rate = 32'd5000000;
    wait_idle();

    // Degenerate baud rates clamp to one clock per bit.
    baud_rate = 32'd0;
    send(8'h81, 1, 1'b0);
    data_valid = 1'b0;
    wait_idle();
    baud_rate = 32'd200000000;
    send(8'h81, 1, 1'b0);
    data_valid = 1'b0;
    wait_idle();

    // Backpressure: bytes offered while the holding register is full are dropped.
    baud_rate = 32'd10000000;
    send(8'h11, 10, 1'b0);
    send(8'h22, 10, 1'b1);
    cnt = 0;
    for (int i = 0; i < 90; i++) begin
      data_in    = 8'($urandom_range(0, 255));
      data_valid = 1'b1;
      if (data_ready) cnt++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    check_eq("bp_accepts", 32'(cnt), 32'd0);
    wait_idle();

    // Reset during data bit 3 with a byte queued.
    send(8'h5A, 10, 1'b0);
    send(8'h77, 10, 1'b1);
    data_valid = 1'b0;
    repeat (43) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_tx", 32'(tx_out), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_ready", 32'(data_ready), 32'd1);
    check_eq("arst_finished", 32'(finished), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check_eq("post_rst_tx", 32'(tx_out), 32'd1);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Recovery after reset.
    send(8'h96, 10, 1'b0);
    data_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
